// File: rtl/dtmf_key_decoder.sv
// DTMF key decoder: maps per-frame row/column FFT bin winners to a key code,
// debounces over consecutive frames, and tracks key-down with a frame watchdog.
module dtmf_key_decoder #(
  parameter logic [5:0] ROW0_BIN       = 6'd19,
  parameter logic [5:0] ROW1_BIN       = 6'd21,
  parameter logic [5:0] ROW2_BIN       = 6'd23,
  parameter logic [5:0] ROW3_BIN       = 6'd25,
  parameter logic [5:0] COL0_BIN       = 6'd33,
  parameter logic [5:0] COL1_BIN       = 6'd36,
  parameter logic [5:0] COL2_BIN       = 6'd40,
  parameter logic [5:0] COL3_BIN       = 6'd43,
  parameter int         BIN_TOL        = 0,
  parameter int         ON_FRAMES      = 3,
  parameter int         OFF_FRAMES     = 2,
  parameter int         TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_valid,
  input  logic [5:0] low_bin,
  input  logic [5:0] high_bin,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAND    = 2'd1,
    LOCKED  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [23:0] ROW_BINS = {ROW3_BIN, ROW2_BIN, ROW1_BIN, ROW0_BIN};
  localparam logic [23:0] COL_BINS = {COL3_BIN, COL2_BIN, COL1_BIN, COL0_BIN};

  state_t      state_reg;
  logic [3:0]  cand_reg;
  logic [3:0]  on_cnt_reg;
  logic [3:0]  off_cnt_reg;
  logic [15:0] wd_cnt_reg;

  logic [3:0]  row_hit;
  logic [3:0]  col_hit;
  logic [1:0]  row_idx;
  logic [1:0]  col_idx;
  logic        pair_ok;
  logic [3:0]  pair_code;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_match
      logic [5:0] row_dist;
      logic [5:0] col_dist;
      assign row_dist = (low_bin >= ROW_BINS[gi*6 +: 6]) ? low_bin - ROW_BINS[gi*6 +: 6]
                                                          : ROW_BINS[gi*6 +: 6] - low_bin;
      assign col_dist = (high_bin >= COL_BINS[gi*6 +: 6]) ? high_bin - COL_BINS[gi*6 +: 6]
                                                           : COL_BINS[gi*6 +: 6] - high_bin;
      // A zero bin means the peak detector found nothing, so it never matches.
      assign row_hit[gi] = (low_bin != 6'd0) && ({26'd0, row_dist} <= 32'(BIN_TOL));
      assign col_hit[gi] = (high_bin != 6'd0) && ({26'd0, col_dist} <= 32'(BIN_TOL));
    end
  endgenerate

  // Lowest matching index wins when tolerance makes neighbouring bins overlap.
  always_comb begin
    row_idx = 2'd0;
    col_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (row_hit[i]) row_idx = 2'(i);
      if (col_hit[i]) col_idx = 2'(i);
    end
  end

  function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0:    key_lookup = 4'd1;
      4'h1:    key_lookup = 4'd2;
      4'h2:    key_lookup = 4'd3;
      4'h3:    key_lookup = 4'd10;
      4'h4:    key_lookup = 4'd4;
      4'h5:    key_lookup = 4'd5;
      4'h6:    key_lookup = 4'd6;
      4'h7:    key_lookup = 4'd11;
      4'h8:    key_lookup = 4'd7;
      4'h9:    key_lookup = 4'd8;
      4'hA:    key_lookup = 4'd9;
      4'hB:    key_lookup = 4'd12;
      4'hC:    key_lookup = 4'd14;
      4'hD:    key_lookup = 4'd0;
      4'hE:    key_lookup = 4'd15;
      default: key_lookup = 4'd13;
    endcase
  endfunction

  assign pair_ok   = (|row_hit) && (|col_hit);
  assign pair_code = key_lookup(row_idx, col_idx);
  assign state_dbg = state_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cand_reg    <= 4'd0;
      on_cnt_reg  <= 4'd0;
      off_cnt_reg <= 4'd0;
      wd_cnt_reg  <= 16'd0;
      key_valid   <= 1'b0;
      key_code    <= 4'd0;
      key_held    <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (frame_valid) begin
        wd_cnt_reg <= 16'd0;
        case (state_reg)
          IDLE: begin
            if (pair_ok) begin
              if (ON_FRAMES == 1) begin
                key_code    <= pair_code;
                key_valid   <= 1'b1;
                key_held    <= 1'b1;
                off_cnt_reg <= 4'd0;
                on_cnt_reg  <= 4'd0;
                state_reg   <= LOCKED;
              end else begin
                cand_reg   <= pair_code;
                on_cnt_reg <= 4'd1;
                state_reg  <= CAND;
              end
            end
          end
          CAND: begin
            if (pair_ok && (pair_code == cand_reg)) begin
              if (on_cnt_reg + 4'd1 == 4'(ON_FRAMES)) begin
                key_code    <= cand_reg;
                key_valid   <= 1'b1;
                key_held    <= 1'b1;
                on_cnt_reg  <= 4'd0;
                off_cnt_reg <= 4'd0;
                state_reg   <= LOCKED;
              end else begin
                on_cnt_reg <= on_cnt_reg + 4'd1;
              end
            end else if (pair_ok) begin
              cand_reg   <= pair_code;
              on_cnt_reg <= 4'd1;
            end else begin
              on_cnt_reg <= 4'd0;
              state_reg  <= IDLE;
            end
          end
          LOCKED: begin
            if (pair_ok && (pair_code == key_code)) begin
              off_cnt_reg <= 4'd0;
            end else if (OFF_FRAMES == 1) begin
              off_cnt_reg <= 4'd0;
              key_held    <= 1'b0;
              state_reg   <= IDLE;
            end else begin
              off_cnt_reg <= 4'd1;
              state_reg   <= RELEASE;
            end
          end
          default: begin
            // A different key here is only an off frame; it must requalify from IDLE.
            if (pair_ok && (pair_code == key_code)) begin
              off_cnt_reg <= 4'd0;
              state_reg   <= LOCKED;
            end else if (off_cnt_reg + 4'd1 == 4'(OFF_FRAMES)) begin
              off_cnt_reg <= 4'd0;
              key_held    <= 1'b0;
              state_reg   <= IDLE;
            end else begin
              off_cnt_reg <= off_cnt_reg + 4'd1;
            end
          end
        endcase
      end else if (wd_cnt_reg >= 16'(TIMEOUT_CYCLES - 1)) begin
        // Frames stopped arriving: force release but keep the last key code.
        wd_cnt_reg  <= 16'(TIMEOUT_CYCLES);
        state_reg   <= IDLE;
        cand_reg    <= 4'd0;
        on_cnt_reg  <= 4'd0;
        off_cnt_reg <= 4'd0;
        key_held    <= 1'b0;
      end else begin
        wd_cnt_reg <= wd_cnt_reg + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dtmf_key_decoder.sv
// Scoreboarded bench for dtmf_key_decoder: expected key pulses are queued with
// the stimulus and matched against every key_valid seen on the falling edge.
module tb_dtmf_key_decoder;
  localparam int TO = 65535;

  logic       clk;
  logic       reset;
  logic       frame_valid;
  logic [5:0] low_bin;
  logic [5:0] high_bin;
  logic       tol_en;

  logic       key_valid, t_key_valid;
  logic [3:0] key_code, t_key_code;
  logic       key_held, t_key_held;
  logic [1:0] state_dbg, t_state_dbg;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [3:0] exp_q[$];
  logic [3:0] tol_q[$];
  logic [3:0] mon_exp, tol_exp;
  logic       kv_prev = 1'b0, t_kv_prev = 1'b0;

  dtmf_key_decoder dut (
    .clk(clk), .reset(reset), .frame_valid(frame_valid),
    .low_bin(low_bin), .high_bin(high_bin),
    .key_valid(key_valid), .key_code(key_code),
    .key_held(key_held), .state_dbg(state_dbg)
  );

  dtmf_key_decoder #(.BIN_TOL(1)) dut_tol (
    .clk(clk), .reset(reset), .frame_valid(frame_valid & tol_en),
    .low_bin(low_bin), .high_bin(high_bin),
    .key_valid(t_key_valid), .key_code(t_key_code),
    .key_held(t_key_held), .state_dbg(t_state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_valid) begin
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL kv_unexpected: got key_valid=1 code=%0d, required no pulse", key_code);
      end else begin
        mon_exp = exp_q.pop_front();
        if (key_code !== mon_exp)
          $display("FAIL kv_code: got %0d, required %0d", key_code, mon_exp);
        else begin
          pass_cnt++;
          $display("key pulse code=%0d ok", key_code);
        end
      end
      chk_cnt++;
      if (kv_prev) $display("FAIL kv_consecutive: got 2 cycles high, required 1");
      else pass_cnt++;
    end
    kv_prev = key_valid;
  end

  always @(negedge clk) begin
    if (t_key_valid) begin
      chk_cnt++;
      if (tol_q.size() == 0) begin
        $display("FAIL tol_kv_unexpected: got key_valid=1 code=%0d, required no pulse", t_key_code);
      end else begin
        tol_exp = tol_q.pop_front();
        if (t_key_code !== tol_exp)
          $display("FAIL tol_kv_code: got %0d, required %0d", t_key_code, tol_exp);
        else begin
          pass_cnt++;
          $display("tol key pulse code=%0d ok", t_key_code);
        end
      end
      chk_cnt++;
      if (t_kv_prev) $display("FAIL tol_kv_consecutive: got 2 cycles high, required 1");
      else pass_cnt++;
    end
    t_kv_prev = t_key_valid;
  end

  // Called at a falling edge; returns at the falling edge after the frame's rising edge.
  task automatic send_frame(input logic [5:0] l, input logic [5:0] h, input bit gap);
    frame_valid = 1'b1;
    low_bin     = l;
    high_bin    = h;
    @(negedge clk);
    frame_valid = 1'b0;
    low_bin     = 6'd0;
    high_bin    = 6'd0;
    $display("frame low=%0d high=%0d -> kv=%b code=%0d held=%b st=%0d",
             l, h, key_valid, key_code, key_held, state_dbg);
    if (gap) @(negedge clk);
  endtask

  task automatic check_state(input string name, input logic [1:0] st, input logic held);
    // Used only to keep state/held comparisons in one place per call site.
    chk_cnt++;
    if (state_dbg !== st) $display("FAIL %s_state: got %0d, required %0d", name, state_dbg, st);
    else pass_cnt++;
    chk_cnt++;
    if (key_held !== held) $display("FAIL %s_held: got %b, required %b", name, key_held, held);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    reset = 1'b1; frame_valid = 1'b0; low_bin = 6'd0; high_bin = 6'd0; tol_en = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (key_valid !== 1'b0) $display("FAIL rst_kv: got %b, required 0", key_valid); else pass_cnt++;
    chk_cnt++;
    if (key_code !== 4'd0) $display("FAIL rst_code: got %0d, required 0", key_code); else pass_cnt++;
    check_state("rst", 2'd0, 1'b0);
  endtask

  task automatic test_basic;
    send_frame(6'd19, 6'd33, 1'b1);
    send_frame(6'd19, 6'd33, 1'b1);
    check_state("basic_cand", 2'd1, 1'b0);
    exp_q.push_back(4'd1);
    send_frame(6'd19, 6'd33, 1'b0);
    chk_cnt++;
    if (key_valid !== 1'b1) $display("FAIL basic_kv_latency: got %b, required 1", key_valid); else pass_cnt++;
    chk_cnt++;
    if (key_code !== 4'd1) $display("FAIL basic_code: got %0d, required 1", key_code); else pass_cnt++;
    check_state("basic_locked", 2'd2, 1'b1);
    @(negedge clk);
    chk_cnt++;
    if (key_valid !== 1'b0) $display("FAIL basic_kv_width: got %b, required 0", key_valid); else pass_cnt++;
    send_frame(6'd0, 6'd0, 1'b1);
    send_frame(6'd0, 6'd0, 1'b1);
    check_state("basic_rel", 2'd0, 1'b0);
  endtask

  task automatic test_retarget;
    send_frame(6'd23, 6'd40, 1'b1);
    send_frame(6'd23, 6'd40, 1'b1);
    send_frame(6'd25, 6'd36, 1'b1);
    send_frame(6'd25, 6'd36, 1'b1);
    exp_q.push_back(4'd0);
    send_frame(6'd25, 6'd36, 1'b0);
    chk_cnt++;
    if (key_valid !== 1'b1) $display("FAIL retarget_kv: got %b, required 1", key_valid); else pass_cnt++;
    chk_cnt++;
    if (key_code !== 4'd0) $display("FAIL retarget_code: got %0d, required 0", key_code); else pass_cnt++;
    send_frame(6'd0, 6'd0, 1'b1);
    send_frame(6'd0, 6'd0, 1'b1);
    check_state("retarget_rel", 2'd0, 1'b0);
  endtask

  task automatic test_dropout;
    send_frame(6'd21, 6'd36, 1'b1);
    send_frame(6'd21, 6'd36, 1'b1);
    exp_q.push_back(4'd5);
    send_frame(6'd21, 6'd36, 1'b1);
    send_frame(6'd0, 6'd36, 1'b1);
    check_state("drop_rel1", 2'd3, 1'b1);
    send_frame(6'd21, 6'd36, 1'b1);
    check_state("drop_relock", 2'd2, 1'b1);
    send_frame(6'd0, 6'd0, 1'b1);
    check_state("drop_rel2", 2'd3, 1'b1);
    send_frame(6'd0, 6'd0, 1'b1);
    check_state("drop_idle", 2'd0, 1'b0);
    chk_cnt++;
    if (key_code !== 4'd5) $display("FAIL drop_code_hold: got %0d, required 5", key_code); else pass_cnt++;
  endtask

  task automatic test_bin_tol;
    tol_en = 1'b1;
    send_frame(6'd20, 6'd33, 1'b1);
    send_frame(6'd20, 6'd33, 1'b1);
    tol_q.push_back(4'd1);
    send_frame(6'd20, 6'd33, 1'b0);
    tol_en = 1'b0;
    check_state("tol0", 2'd0, 1'b0);
    chk_cnt++;
    if (t_key_held !== 1'b1) $display("FAIL tol1_held: got %b, required 1", t_key_held); else pass_cnt++;
    chk_cnt++;
    if (t_key_code !== 4'd1) $display("FAIL tol1_code: got %0d, required 1", t_key_code); else pass_cnt++;
    chk_cnt++;
    if (t_state_dbg !== 2'd2) $display("FAIL tol1_state: got %0d, required 2", t_state_dbg); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    send_frame(6'd21, 6'd43, 1'b0);
    send_frame(6'd21, 6'd43, 1'b0);
    exp_q.push_back(4'd11);
    send_frame(6'd21, 6'd43, 1'b0);
    chk_cnt++;
    if (key_valid !== 1'b1) $display("FAIL b2b_kv: got %b, required 1", key_valid); else pass_cnt++;
    send_frame(6'd19, 6'd33, 1'b0);
    check_state("b2b_other", 2'd3, 1'b1);
    send_frame(6'd19, 6'd33, 1'b0);
    check_state("b2b_idle", 2'd0, 1'b0);
    send_frame(6'd19, 6'd33, 1'b0);
    send_frame(6'd19, 6'd33, 1'b0);
    exp_q.push_back(4'd1);
    send_frame(6'd19, 6'd33, 1'b0);
    chk_cnt++;
    if (key_code !== 4'd1) $display("FAIL b2b_code: got %0d, required 1", key_code); else pass_cnt++;
    send_frame(6'd0, 6'd0, 1'b0);
    send_frame(6'd0, 6'd0, 1'b1);
    check_state("b2b_rel", 2'd0, 1'b0);
  endtask

  task automatic test_timeout;
    send_frame(6'd25, 6'd43, 1'b1);
    send_frame(6'd25, 6'd43, 1'b1);
    exp_q.push_back(4'd13);
    send_frame(6'd25, 6'd43, 1'b0);
    repeat (TO - 1) @(negedge clk);
    check_state("to_before", 2'd2, 1'b1);
    @(negedge clk);
    check_state("to_fired", 2'd0, 1'b0);
    chk_cnt++;
    if (key_code !== 4'd13) $display("FAIL to_code: got %0d, required 13", key_code); else pass_cnt++;
    $display("timeout released after %0d idle cycles", TO);
  endtask

  task automatic test_reset_mid;
    send_frame(6'd19, 6'd33, 1'b0);
    send_frame(6'd19, 6'd33, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_cnt++;
    if (key_code !== 4'd0) $display("FAIL rmid_code: got %0d, required 0", key_code); else pass_cnt++;
    check_state("rmid", 2'd0, 1'b0);
    send_frame(6'd19, 6'd33, 1'b0);
    chk_cnt++;
    if (key_valid !== 1'b0) $display("FAIL rmid_kv: got %b, required 0", key_valid); else pass_cnt++;
    check_state("rmid_cand", 2'd1, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_scoreboard_drain;
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL sb_drain: got %0d pending, required 0", exp_q.size());
    else pass_cnt++;
    chk_cnt++;
    if (tol_q.size() != 0) $display("FAIL sb_tol_drain: got %0d pending, required 0", tol_q.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_retarget;
    test_dropout;
    test_bin_tol;
    test_back_to_back;
    test_timeout;
    test_reset_mid;
    test_scoreboard_drain;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
